exe_stage_module: RTL and testbench
===================================

Name: exe_stage_module

Overview:
Execute stage of the 5-stage ARM pipeline. It is the consumer side of the ID/EX register interface and does the following:
- Takes decoded control signals, operands and shifter fields from ID/EX.
- Applies operand forwarding and generates Val2.
- Runs the ALU and computes the branch target.
- Owns the NZCV status register.
- Registers results into EX/MEM for the memory stage.

Parameters:
DATA_W, 32, datapath / register-file word width
ADDR_W, 32, PC and branch address width
REG_ADDR_W, 4, register-file address width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
freeze  in  1  hold EX/MEM register and status register
wb_en_in  in  1  ID/EX write-back enable
mem_r_en_in  in  1  ID/EX load
mem_w_en_in  in  1  ID/EX store
b_in  in  1  ID/EX branch
s_in  in  1  ID/EX status-update (S bit)
exec_cmd_in  in  4  ALU command
pc_in  in  ADDR_W  PC+4 of instruction
val_r_n_in  in  DATA_W  Rn value
val_r_m_in  in  DATA_W  Rm value
imm_in  in  1  immediate operand flag
shift_operand_in  in  12  shifter operand field
signed_imm_24_in  in  24  branch offset
dest_in  in  REG_ADDR_W  destination register
src_1_in, src_2_in  in  REG_ADDR_W  source register ids (to forwarding unit)
sel_src_1, sel_src_2  in  2  forward select: 0 reg, 1 mem_alu_result, 2 wb_result
mem_alu_result  in  DATA_W  EX/MEM result (forward)
wb_result  in  DATA_W  write-back value (forward)
branch_taken  out  1  combinational, equals b_in
branch_address  out  ADDR_W  combinational branch target
status_reg_out  out  4  NZCV {N,Z,C,V}
wb_en_out, mem_r_en_out, mem_w_en_out  out  1  registered controls
alu_result  out  DATA_W  registered ALU result / memory address
st_val  out  DATA_W  registered store data (forwarded Rm)
dest_out  out  REG_ADDR_W  registered destination

Behaviour:
- Reset (rst=0, async): all registered outputs and the status register clear to 0.
- Operand select:
  - op1 = mux(sel_src_1: val_r_n_in / mem_alu_result / wb_result).
  - opm = same mux on sel_src_2 over val_r_m_in.
  - Select value 3 behaves as 0.
- Val2 generation:
  - imm_in=1: zero-extended imm8 = shift_operand[7:0], rotated right by 2*shift_operand[11:8].
  - Else if mem_r_en_in or mem_w_en_in: zero-extended shift_operand[11:0].
  - Else: opm shifted by shift_operand[11:7] per shift_operand[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR). A shift amount of 0 passes opm unchanged.
- ALU commands (C_in = status_reg_out[1]):
  - 0001 MOV: Val2
  - 1001 MVN: ~Val2
  - 0010 ADD: op1+Val2
  - 0011 ADC: op1+Val2+C_in
  - 0100 SUB/CMP: op1-Val2
  - 0101 SBC: op1-Val2-~C_in
  - 0110 AND/TST: op1&Val2
  - 0111 ORR: op1|Val2
  - 1000 EOR: op1^Val2
  - Any other command: result 0.
- Flags:
  - N = result[31]; Z = (result==0).
  - C = carry-out of the 33-bit add; for subtract, C = NOT borrow.
  - V = signed overflow.
  - Logical ops and MOV/MVN keep C and V unchanged.
- Status register: loads the new NZCV on posedge clk when s_in=1 and freeze=0. Otherwise it holds.
- Branch: branch_address = pc_in + (sign-extend(signed_imm_24_in) << 2), truncated to ADDR_W. Wrap-around is ignored.
- EX/MEM register: one-cycle latency, captured on posedge clk when freeze=0 and held when freeze=1. It captures wb_en, mem_r_en, mem_w_en, alu_result, st_val = opm, and dest.
- Bubbles: a bubble from ID/EX (all enables 0) propagates as enables 0; no internal flush is needed.
- Reset while frozen: reset wins.

Optional Feature:
FORWARDING_EN
- Defined: sel_src_1/sel_src_2 muxes are active as described above.
- Undefined: op1=val_r_n_in and opm=val_r_m_in. The sel and forward inputs remain as ports but are ignored; hazards are handled by stalls upstream.

Decomposition:
- Shared package / Constants.v holds:
  - EXEC_* command codes
  - SHIFT_LSL/LSR/ASR/ROR
  - FWD_SEL_* codes
  - STATUS_N/Z/C/V bit indices
  - existing *_LEN widths
- One sub-module, val2_generator (combinational). The ALU stays inline or in alu if preferred.

Test Plan:
1. ADD with s_in=1: op1=0x7FFFFFFF, imm_in=1, shift_operand=0x001. Next cycle alu_result=0x80000000 and NZCV=1001.
2. SUB/CMP with s_in=1: op1=5, Val2=5. NZCV=0110; with s_in=0, NZCV unchanged.
3. Shifts: Rm=0x80000001 with shift_operand field ROR#1 gives alu_result=0xC0000000 under MOV. ASR#4 of 0x80000000 gives 0xF8000000.
4. Forwarding: sel_src_1=1, mem_alu_result=0x10, ADD imm 4 gives 0x14. sel_src_2=2 makes st_val=wb_result. Without FORWARDING_EN, the result uses val_r_n_in.
5. Branch: pc_in=0x100, signed_imm_24=0xFFFFFE gives branch_address=0xF8 and branch_taken=1 in the same cycle.
6. Freeze: freeze=1 for 2 cycles holds all outputs and NZCV. Asserting rst=0 mid-freeze asynchronously zeroes all outputs.

Source files
------------

// File: rtl/exe_stage_module_pkg.sv
// Shared constants and types for the ARM execute stage.
// Command codes, shifter types, forward selects and NZCV layout.
package exe_stage_module_pkg;

  localparam int EXEC_CMD_LEN      = 4;
  localparam int SHIFT_OPERAND_LEN = 12;
  localparam int SIGNED_IMM_LEN    = 24;
  localparam int STATUS_LEN        = 4;
  localparam int FWD_SEL_LEN       = 2;

  localparam logic [3:0] EXEC_MOV = 4'b0001;
  localparam logic [3:0] EXEC_MVN = 4'b1001;
  localparam logic [3:0] EXEC_ADD = 4'b0010;
  localparam logic [3:0] EXEC_ADC = 4'b0011;
  localparam logic [3:0] EXEC_SUB = 4'b0100;
  localparam logic [3:0] EXEC_SBC = 4'b0101;
  localparam logic [3:0] EXEC_AND = 4'b0110;
  localparam logic [3:0] EXEC_ORR = 4'b0111;
  localparam logic [3:0] EXEC_EOR = 4'b1000;

  localparam logic [1:0] SHIFT_LSL = 2'b00;
  localparam logic [1:0] SHIFT_LSR = 2'b01;
  localparam logic [1:0] SHIFT_ASR = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

  localparam logic [1:0] FWD_SEL_REG = 2'd0;
  localparam logic [1:0] FWD_SEL_MEM = 2'd1;
  localparam logic [1:0] FWD_SEL_WB  = 2'd2;

  localparam int STATUS_N = 3;
  localparam int STATUS_Z = 2;
  localparam int STATUS_C = 1;
  localparam int STATUS_V = 0;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

endpackage

// File: rtl/exe_stage_module_val2.sv
// Val2 generator: rotated immediate, memory offset or shifted Rm.
// Purely combinational; feeds the execute-stage ALU.
module val2_generator
  import exe_stage_module_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                         imm,
  input  logic                         mem_en,
  input  logic [SHIFT_OPERAND_LEN-1:0] shift_operand,
  input  logic [DATA_W-1:0]            val_rm,
  output logic [DATA_W-1:0]            val2
);

  logic [DATA_W-1:0]   imm_ext;
  logic [DATA_W-1:0]   off_ext;
  logic [4:0]          rot;
  logic [4:0]          amt;
  logic [1:0]          sh_type;
  logic [2*DATA_W-1:0] imm_dbl;
  logic [2*DATA_W-1:0] rm_dbl;
  logic [DATA_W-1:0]   asr_val;

  assign imm_ext = {{(DATA_W-8){1'b0}}, shift_operand[7:0]};
  assign off_ext = {{(DATA_W-12){1'b0}}, shift_operand};
  assign rot     = {shift_operand[11:8], 1'b0};
  assign amt     = shift_operand[11:7];
  assign sh_type = shift_operand[6:5];

  // Rotates done on a doubled word so a zero amount needs no special case
  assign imm_dbl = {imm_ext, imm_ext} >> rot;
  assign rm_dbl  = {val_rm, val_rm} >> amt;
  assign asr_val = $signed(val_rm) >>> amt;

  always_comb begin
    val2 = val_rm;
    if (imm) begin
      val2 = imm_dbl[DATA_W-1:0];
    end else if (mem_en) begin
      val2 = off_ext;
    end else begin
      case (sh_type)
        SHIFT_LSL: val2 = val_rm << amt;
        SHIFT_LSR: val2 = val_rm >> amt;
        SHIFT_ASR: val2 = asr_val;
        SHIFT_ROR: val2 = rm_dbl[DATA_W-1:0];
        default:   val2 = val_rm;
      endcase
    end
  end

endmodule

// File: rtl/exe_stage_module.sv
// ARM execute stage: forwarding, Val2, ALU, NZCV and EX/MEM register.
// FORWARDING_EN enables the sel_src_1/sel_src_2 operand muxes.
module exe_stage_module
  import exe_stage_module_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         freeze,
  input  logic                         wb_en_in,
  input  logic                         mem_r_en_in,
  input  logic                         mem_w_en_in,
  input  logic                         b_in,
  input  logic                         s_in,
  input  logic [EXEC_CMD_LEN-1:0]      exec_cmd_in,
  input  logic [ADDR_W-1:0]            pc_in,
  input  logic [DATA_W-1:0]            val_r_n_in,
  input  logic [DATA_W-1:0]            val_r_m_in,
  input  logic                         imm_in,
  input  logic [SHIFT_OPERAND_LEN-1:0] shift_operand_in,
  input  logic [SIGNED_IMM_LEN-1:0]    signed_imm_24_in,
  input  logic [REG_ADDR_W-1:0]        dest_in,
  input  logic [REG_ADDR_W-1:0]        src_1_in,
  input  logic [REG_ADDR_W-1:0]        src_2_in,
  input  logic [FWD_SEL_LEN-1:0]       sel_src_1,
  input  logic [FWD_SEL_LEN-1:0]       sel_src_2,
  input  logic [DATA_W-1:0]            mem_alu_result,
  input  logic [DATA_W-1:0]            wb_result,
  output logic                         branch_taken,
  output logic [ADDR_W-1:0]            branch_address,
  output logic [STATUS_LEN-1:0]        status_reg_out,
  output logic                         wb_en_out,
  output logic                         mem_r_en_out,
  output logic                         mem_w_en_out,
  output logic [DATA_W-1:0]            alu_result,
  output logic [DATA_W-1:0]            st_val,
  output logic [REG_ADDR_W-1:0]        dest_out
);

  logic [DATA_W-1:0]     op1;
  logic [DATA_W-1:0]     opm;
  logic [DATA_W-1:0]     val2;
  logic [DATA_W-1:0]     res;
  logic [DATA_W:0]       sum;
  logic [ADDR_W-1:0]     br_off;
  nzcv_t                 flags;
  nzcv_t                 status_q, status_d;
  logic                  wb_en_q, wb_en_d;
  logic                  mem_r_en_q, mem_r_en_d;
  logic                  mem_w_en_q, mem_w_en_d;
  logic [DATA_W-1:0]     alu_q, alu_d;
  logic [DATA_W-1:0]     st_q, st_d;
  logic [REG_ADDR_W-1:0] dest_q, dest_d;
  logic                  c_in;
  logic                  msb1, msb2, msbr;

`ifdef FORWARDING_EN
  always_comb begin
    case (sel_src_1)
      FWD_SEL_MEM: op1 = mem_alu_result;
      FWD_SEL_WB:  op1 = wb_result;
      default:     op1 = val_r_n_in;
    endcase
    case (sel_src_2)
      FWD_SEL_MEM: opm = mem_alu_result;
      FWD_SEL_WB:  opm = wb_result;
      default:     opm = val_r_m_in;
    endcase
  end

  logic unused_fwd;
  assign unused_fwd = ^{src_1_in, src_2_in};
`else
  assign op1 = val_r_n_in;
  assign opm = val_r_m_in;

  // Hazards are resolved by upstream stalls in this build
  logic unused_fwd;
  assign unused_fwd = ^{src_1_in, src_2_in, sel_src_1, sel_src_2,
                        mem_alu_result, wb_result};
`endif

  val2_generator #(
    .DATA_W(DATA_W)
  ) u_val2 (
    .imm          (imm_in),
    .mem_en       (mem_r_en_in | mem_w_en_in),
    .shift_operand(shift_operand_in),
    .val_rm       (opm),
    .val2         (val2)
  );

  assign c_in = status_q.c;
  assign msb1 = op1[DATA_W-1];
  assign msb2 = val2[DATA_W-1];
  assign msbr = res[DATA_W-1];

  always_comb begin
    sum   = '0;
    res   = '0;
    flags = status_q;
    unique case (exec_cmd_in)
      EXEC_MOV: res = val2;
      EXEC_MVN: res = ~val2;
      EXEC_ADD: begin
        sum = {1'b0, op1} + {1'b0, val2};
        res = sum[DATA_W-1:0];
      end
      EXEC_ADC: begin
        sum = {1'b0, op1} + {1'b0, val2} + {{DATA_W{1'b0}}, c_in};
        res = sum[DATA_W-1:0];
      end
      EXEC_SUB: begin
        sum = {1'b0, op1} - {1'b0, val2};
        res = sum[DATA_W-1:0];
      end
      EXEC_SBC: begin
        sum = {1'b0, op1} - {1'b0, val2} - {{DATA_W{1'b0}}, ~c_in};
        res = sum[DATA_W-1:0];
      end
      EXEC_AND: res = op1 & val2;
      EXEC_ORR: res = op1 | val2;
      EXEC_EOR: res = op1 ^ val2;
      default:  res = '0;
    endcase
    flags.n = res[DATA_W-1];
    flags.z = (res == '0);
    unique case (exec_cmd_in)
      EXEC_ADD, EXEC_ADC: begin
        flags.c = sum[DATA_W];
        flags.v = (msb1 == msb2) && (msbr != msb1);
      end
      // Subtract carry is inverted borrow
      EXEC_SUB, EXEC_SBC: begin
        flags.c = ~sum[DATA_W];
        flags.v = (msb1 != msb2) && (msbr != msb1);
      end
      default: ;
    endcase
  end

  assign br_off = {{(ADDR_W-SIGNED_IMM_LEN){signed_imm_24_in[SIGNED_IMM_LEN-1]}},
                   signed_imm_24_in} << 2;
  assign branch_address = pc_in + br_off;
  assign branch_taken   = b_in;

  always_comb begin
    status_d   = (s_in && !freeze) ? flags : status_q;
    wb_en_d    = freeze ? wb_en_q    : wb_en_in;
    mem_r_en_d = freeze ? mem_r_en_q : mem_r_en_in;
    mem_w_en_d = freeze ? mem_w_en_q : mem_w_en_in;
    alu_d      = freeze ? alu_q      : res;
    st_d       = freeze ? st_q       : opm;
    dest_d     = freeze ? dest_q     : dest_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q   <= '0;
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
      alu_q      <= '0;
      st_q       <= '0;
      dest_q     <= '0;
    end else begin
      status_q   <= status_d;
      wb_en_q    <= wb_en_d;
      mem_r_en_q <= mem_r_en_d;
      mem_w_en_q <= mem_w_en_d;
      alu_q      <= alu_d;
      st_q       <= st_d;
      dest_q     <= dest_d;
    end
  end

  assign status_reg_out = status_q;
  assign wb_en_out      = wb_en_q;
  assign mem_r_en_out   = mem_r_en_q;
  assign mem_w_en_out   = mem_w_en_q;
  assign alu_result     = alu_q;
  assign st_val         = st_q;
  assign dest_out       = dest_q;

endmodule

// File: tb/tb_exe_stage_module.sv
// Bench for exe_stage_module: vector table through a scoreboard,
// plus branch, forwarding, freeze and async-reset sequences.
module tb_exe_stage_module;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in;
  logic [3:0]  exec_cmd_in;
  logic [31:0] pc_in, val_r_n_in, val_r_m_in;
  logic        imm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic [3:0]  dest_in, src_1_in, src_2_in;
  logic [1:0]  sel_src_1, sel_src_2;
  logic [31:0] mem_alu_result, wb_result;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic [3:0]  status_reg_out;
  logic        wb_en_out, mem_r_en_out, mem_w_en_out;
  logic [31:0] alu_result, st_val;
  logic [3:0]  dest_out;

  int errors = 0;
  int checks = 0;

  exe_stage_module dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .b_in(b_in), .s_in(s_in),
    .exec_cmd_in(exec_cmd_in), .pc_in(pc_in),
    .val_r_n_in(val_r_n_in), .val_r_m_in(val_r_m_in),
    .imm_in(imm_in), .shift_operand_in(shift_operand_in),
    .signed_imm_24_in(signed_imm_24_in), .dest_in(dest_in),
    .src_1_in(src_1_in), .src_2_in(src_2_in),
    .sel_src_1(sel_src_1), .sel_src_2(sel_src_2),
    .mem_alu_result(mem_alu_result), .wb_result(wb_result),
    .branch_taken(branch_taken), .branch_address(branch_address),
    .status_reg_out(status_reg_out), .wb_en_out(wb_en_out),
    .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
    .alu_result(alu_result), .st_val(st_val), .dest_out(dest_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cmd;
    logic        s, imm, wb, mr, mw;
    logic [31:0] rn, rm;
    logic [11:0] shop;
    logic [31:0] res;
    logic [3:0]  nzcv;
  } vec_t;

  typedef struct {
    logic [31:0] res, st;
    logic [3:0]  dest, nzcv;
    logic        wb, mr, mw;
  } exp_t;

  vec_t vt[21];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input int idx);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1 (%0d)", idx);
    end else begin
      e = sb.pop_front();
      chk($sformatf("alu_result[%0d]", idx), alu_result, e.res);
      chk($sformatf("st_val[%0d]", idx), st_val, e.st);
      chk($sformatf("dest[%0d]", idx), {28'd0, dest_out}, {28'd0, e.dest});
      chk($sformatf("nzcv[%0d]", idx), {28'd0, status_reg_out},
          {28'd0, e.nzcv});
      chk($sformatf("en[%0d]", idx),
          {29'd0, wb_en_out, mem_r_en_out, mem_w_en_out},
          {29'd0, e.wb, e.mr, e.mw});
    end
  endtask

  task automatic run(input vec_t v, input logic [3:0] d,
                     input logic [31:0] st_exp, input int idx);
    exp_t e;
    @(negedge clk);
    exec_cmd_in      = v.cmd;
    s_in             = v.s;
    imm_in           = v.imm;
    wb_en_in         = v.wb;
    mem_r_en_in      = v.mr;
    mem_w_en_in      = v.mw;
    val_r_n_in       = v.rn;
    val_r_m_in       = v.rm;
    shift_operand_in = v.shop;
    dest_in          = d;
    e.res  = v.res;
    e.st   = st_exp;
    e.dest = d;
    e.nzcv = v.nzcv;
    e.wb   = v.wb;
    e.mr   = v.mr;
    e.mw   = v.mw;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out(idx);
  endtask

  initial begin
    vec_t fv;
    logic [31:0] exp_r;
    //          cmd     s     imm   wb    mr    mw    rn            rm            shop     res           nzcv
    vt[0]  = '{4'b0010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h7FFFFFFF, 32'hA5A50000, 12'h001, 32'h80000000, 4'b1001};
    vt[1]  = '{4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000005, 32'hA5A50001, 12'h005, 32'h00000000, 4'b0110};
    vt[2]  = '{4'b0100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00000009, 32'hA5A50002, 12'h005, 32'h00000004, 4'b0110};
    vt[3]  = '{4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 32'h80000001, 12'h0E0, 32'hC0000000, 4'b0110};
    vt[4]  = '{4'b0001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 32'h80000000, 12'h240, 32'hF8000000, 4'b1010};
    vt[5]  = '{4'b1001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00000000, 32'hA5A50005, 12'h000, 32'hFFFFFFFF, 4'b1010};
    vt[6]  = '{4'b0011, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00000001, 32'hA5A50006, 12'h001, 32'h00000003, 4'b0000};
    vt[7]  = '{4'b0101, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00000005, 32'hA5A50007, 12'h002, 32'h00000002, 4'b0010};
    vt[8]  = '{4'b0110, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h000000F0, 32'hA5A50008, 12'h00F, 32'h00000000, 4'b0110};
    vt[9]  = '{4'b0111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h000000F0, 32'hA5A50009, 12'h00F, 32'h000000FF, 4'b0110};
    vt[10] = '{4'b1000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h000000FF, 32'hA5A5000A, 12'h00F, 32'h000000F0, 4'b0110};
    vt[11] = '{4'b0001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00000000, 32'hA5A5000B, 12'h4FF, 32'hFF000000, 4'b1010};
    vt[12] = '{4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00001000, 32'hA5A5000C, 12'hFFF, 32'h00001FFF, 4'b1010};
    vt[13] = '{4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 32'h00000001, 12'hF80, 32'h80000000, 4'b1010};
    vt[14] = '{4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 32'h80000000, 12'h0A0, 32'h40000000, 4'b1010};
    vt[15] = '{4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 32'h00001234, 12'h060, 32'h00001234, 4'b1010};
    vt[16] = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h12345678, 32'h00000055, 12'h000, 32'h00000000, 4'b1010};
    vt[17] = '{4'b0010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hA5A50011, 12'h001, 32'h00000000, 4'b0110};
    vt[18] = '{4'b0100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00000003, 32'hA5A50012, 12'h005, 32'hFFFFFFFE, 4'b1000};
    vt[19] = '{4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00002000, 32'hCAFEF00D, 12'h010, 32'h00002010, 4'b1000};
    vt[20] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 12'h000, 32'h00000000, 4'b1000};

    rst = 1'b0; freeze = 1'b0;
    wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; b_in = 0; s_in = 0;
    exec_cmd_in = 0; pc_in = 0; val_r_n_in = 0; val_r_m_in = 0;
    imm_in = 0; shift_operand_in = 0; signed_imm_24_in = 0;
    dest_in = 0; src_1_in = 0; src_2_in = 0;
    sel_src_1 = 0; sel_src_2 = 0; mem_alu_result = 0; wb_result = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_alu", alu_result, 32'h0);
    chk("reset_nzcv", {28'd0, status_reg_out}, 32'h0);
    chk("reset_en", {29'd0, wb_en_out, mem_r_en_out, mem_w_en_out}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 21; i++)
      run(vt[i], 4'(i), vt[i].rm, i);

    // Branch target is combinational
    @(negedge clk);
    b_in = 1'b1; pc_in = 32'h100; signed_imm_24_in = 24'hFFFFFE;
    #1;
    chk("br_addr_back", branch_address, 32'h000000F8);
    chk("br_taken", {31'd0, branch_taken}, 32'd1);
    signed_imm_24_in = 24'h000010;
    #1;
    chk("br_addr_fwd", branch_address, 32'h00000140);
    b_in = 1'b0;
    #1;
    chk("br_not_taken", {31'd0, branch_taken}, 32'd0);

    // Forwarding: mem result on op1, wb result on Rm
    sel_src_1 = 2'd1; sel_src_2 = 2'd2;
    mem_alu_result = 32'h10; wb_result = 32'hBEEF;
`ifdef FORWARDING_EN
    exp_r = 32'h14;
    fv = '{4'b0010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h999, 32'h1111, 12'h004, exp_r, 4'b1000};
    run(fv, 4'd3, 32'hBEEF, 100);
`else
    exp_r = 32'h99D;
    fv = '{4'b0010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h999, 32'h1111, 12'h004, exp_r, 4'b1000};
    run(fv, 4'd3, 32'h1111, 100);
`endif
    sel_src_1 = 2'd3; sel_src_2 = 2'd3;
    fv = '{4'b0010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h2222, 12'h004, 32'h24, 4'b1000};
    run(fv, 4'd4, 32'h2222, 101);
    sel_src_1 = 2'd0; sel_src_2 = 2'd0;

    // Freeze holds EX/MEM and NZCV, then reset mid-freeze clears
    fv = '{4'b0010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h3333, 12'h001, 32'h80000000, 4'b1001};
    run(fv, 4'd7, 32'h3333, 102);
    @(negedge clk);
    freeze = 1'b1;
    exec_cmd_in = 4'b0100; s_in = 1'b1; imm_in = 1'b1;
    val_r_n_in = 32'h5; shift_operand_in = 12'h005;
    val_r_m_in = 32'h4444; dest_in = 4'd9; wb_en_in = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("frz_alu[%0d]", k), alu_result, 32'h80000000);
      chk($sformatf("frz_st[%0d]", k), st_val, 32'h3333);
      chk($sformatf("frz_dest[%0d]", k), {28'd0, dest_out}, 32'd7);
      chk($sformatf("frz_wb[%0d]", k), {31'd0, wb_en_out}, 32'd1);
      chk($sformatf("frz_nzcv[%0d]", k), {28'd0, status_reg_out}, 32'h9);
    end
    #2;
    rst = 1'b0;
    #1;
    chk("rst_frz_alu", alu_result, 32'h0);
    chk("rst_frz_st", st_val, 32'h0);
    chk("rst_frz_dest", {28'd0, dest_out}, 32'h0);
    chk("rst_frz_wb", {31'd0, wb_en_out}, 32'h0);
    chk("rst_frz_nzcv", {28'd0, status_reg_out}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    freeze = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
